// File: rtl/cache_pkg.sv
// Shared types and constants for the associative cache set.
//   replace_mode_e : replacement policy selector (LRU, FIFO, RANDOM)
//   set_state_e    : set controller state (idle, line fill, flush walk)
//   LFSR_SEED/TAPS : 8-bit LFSR for x^8+x^6+x^5+x^4+1, shifting left
//   lfsr_next      : one LFSR step
package cache_pkg;

    typedef enum logic [1:0] {
        RM_LRU    = 2'd0,
        RM_FIFO   = 2'd1,
        RM_RANDOM = 2'd2
    } replace_mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_FLUSH = 2'd2
    } set_state_e;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    // Feedback taps at bits 7,5,4,3 realise x^8+x^6+x^5+x^4+1.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/assoc_set_replacer.sv
// Replacement state for one cache set: LRU ages, FIFO pointer and a
// free-running LFSR, plus victim selection.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   valid_i          per-way valid bits (invalid ways are preferred victims)
//   touch_i          access hit: make touch_way_i most recently used
//   touch_way_i      way that was hit
//   commit_i         line fill committed into commit_way_i
//   commit_way_i     way that was filled
//   victim_way_o     current victim (lowest invalid way, else policy choice)
module set_replacer
    import cache_pkg::*;
#(
    parameter int unsigned WAYS         = 4,
    parameter int unsigned REPLACE_MODE = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WAYS-1:0]          valid_i,
    input  logic                     touch_i,
    input  logic [$clog2(WAYS)-1:0]  touch_way_i,
    input  logic                     commit_i,
    input  logic [$clog2(WAYS)-1:0]  commit_way_i,
    output logic [$clog2(WAYS)-1:0]  victim_way_o
);

    localparam int unsigned WW = $clog2(WAYS);

    logic [WW-1:0] age_q [WAYS];
    logic [WW-1:0] age_d [WAYS];
    logic [WW-1:0] ptr_q, ptr_d;
    logic [7:0]    lfsr_q;

    logic          upd;
    logic [WW-1:0] upd_way;
    logic [WW-1:0] lru_way;
    logic [WW-1:0] max_age;
    logic          inv_found;
    logic [WW-1:0] inv_way;

    // A fill commit and a touch in the same cycle: the freshly filled
    // line becomes most recently used.
    assign upd     = commit_i | touch_i;
    assign upd_way = commit_i ? commit_way_i : touch_way_i;

    // Ages form a permutation of 0..WAYS-1; 0 is most recently used.
    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            age_d[i] = age_q[i];
        end
        if (upd) begin
            for (int i = 0; i < WAYS; i++) begin
                if (WW'(i) == upd_way) begin
                    age_d[i] = '0;
                end else if (age_q[i] < age_q[upd_way]) begin
                    age_d[i] = age_q[i] + WW'(1);
                end
            end
        end
    end

    assign ptr_d = commit_i ? ptr_q + WW'(1) : ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < WAYS; i++) begin
                age_q[i] <= WW'(i);
            end
            ptr_q  <= '0;
            lfsr_q <= LFSR_SEED;
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                age_q[i] <= age_d[i];
            end
            ptr_q  <= ptr_d;
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    always_comb begin
        lru_way   = '0;
        max_age   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (age_q[i] >= max_age) begin
                max_age = age_q[i];
                lru_way = WW'(i);
            end
            if (!valid_i[i] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WW'(i);
            end
        end
    end

    always_comb begin
        victim_way_o = lru_way;
        if (inv_found) begin
            victim_way_o = inv_way;
        end else begin
            case (REPLACE_MODE)
                int'(RM_FIFO):   victim_way_o = ptr_q;
                int'(RM_RANDOM): victim_way_o = lfsr_q[WW-1:0];
                default:         victim_way_o = lru_way;
            endcase
        end
    end

endmodule

// File: rtl/assoc_set.sv
// One N-way associative cache set: tag/valid/dirty/data storage, hit
// detection, byte-enable CPU writes, multi-cycle line fill into a latched
// victim, and a dirty-line flush walker.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   addr_i                       CPU address (tag + word select)
//   cpu_we_i/byte_en_i/write_data_i  byte-enable write into the hit way
//   touch_i                      access event for the replacement policy
//   fill_start_i                 latch victim and tag of addr_i, enter FILL
//   fill_we_i/fill_addr_i/fill_data_i/fill_last_i  fill word stream
//   flush_start_i/flush_inv_i    start flush walk (optionally invalidating)
//   flush_ready_i/flush_word_i   write-back handshake and word select
//   hit_o/hit_way_o              tag match on a valid way
//   victim_way_o                 replacement victim (latched during FILL)
//   dirty_o/tag_o/read_data_o    status of hit way, else of victim way
//   busy_o                       controller not idle
//   flush_valid_o/flush_way_o/flush_tag_o/flush_data_o  dirty line offered
//   flush_done_o                 one-cycle pulse when the walk completes
// Flush handshake: flush_valid_o stays high with a stable way until
// flush_ready_i; the line retires on the clock edge where both are high.
module assoc_set
    import cache_pkg::*;
#(
    parameter int unsigned TAG_WIDTH    = 26,
    parameter int unsigned OFFSET_WIDTH = 4,
    parameter int unsigned WAYS         = 4,
    parameter int unsigned REPLACE_MODE = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [31:0]               addr_i,
    input  logic                      cpu_we_i,
    input  logic [3:0]                byte_en_i,
    input  logic [31:0]               write_data_i,
    input  logic                      touch_i,
    input  logic                      fill_start_i,
    input  logic                      fill_we_i,
    input  logic [31:0]               fill_addr_i,
    input  logic [31:0]               fill_data_i,
    input  logic                      fill_last_i,
    input  logic                      flush_start_i,
    input  logic                      flush_inv_i,
    input  logic                      flush_ready_i,
    input  logic [OFFSET_WIDTH-3:0]   flush_word_i,
    output logic                      hit_o,
    output logic [$clog2(WAYS)-1:0]   hit_way_o,
    output logic [$clog2(WAYS)-1:0]   victim_way_o,
    output logic                      dirty_o,
    output logic [TAG_WIDTH-1:0]      tag_o,
    output logic [31:0]               read_data_o,
    output logic                      busy_o,
    output logic                      flush_valid_o,
    output logic [$clog2(WAYS)-1:0]   flush_way_o,
    output logic [TAG_WIDTH-1:0]      flush_tag_o,
    output logic [31:0]               flush_data_o,
    output logic                      flush_done_o
);

    localparam int unsigned WW    = $clog2(WAYS);
    localparam int unsigned WDW   = OFFSET_WIDTH - 2;
    localparam int unsigned WORDS = 2 ** WDW;

    set_state_e           state_q, state_d;
    logic [WW-1:0]        lat_way_q, lat_way_d;
    logic [TAG_WIDTH-1:0] lat_tag_q, lat_tag_d;
    logic [WW-1:0]        idx_q, idx_d;
    logic                 inv_q, inv_d;
    logic [WAYS-1:0]      valid_q, valid_d;
    logic [WAYS-1:0]      dirty_q, dirty_d;

    logic [TAG_WIDTH-1:0] tag_q  [WAYS];
    logic [31:0]          data_q [WAYS][WORDS];

    logic [TAG_WIDTH-1:0] addr_tag;
    logic [WDW-1:0]       cpu_word;
    logic [WDW-1:0]       fill_word;
    logic                 hit;
    logic [WW-1:0]        hit_way;
    logic [WW-1:0]        rep_victim;
    logic [WW-1:0]        sel_way;
    logic                 cpu_wr, fill_wr, commit;
    logic                 in_flush, cur_dirty, retire;
    logic                 unused_bits;

    assign addr_tag    = addr_i[31 -: TAG_WIDTH];
    assign cpu_word    = addr_i[OFFSET_WIDTH-1:2];
    assign fill_word   = fill_addr_i[OFFSET_WIDTH-1:2];
    assign unused_bits = ^{addr_i, fill_addr_i};

    // The way being refilled holds a partial line, so it never hits.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (valid_q[i] && tag_q[i] == addr_tag &&
                !(state_q == S_FILL && lat_way_q == WW'(i))) begin
                if (!hit) begin
                    hit_way = WW'(i);
                end
                hit = 1'b1;
            end
        end
    end

    set_replacer #(
        .WAYS         (WAYS),
        .REPLACE_MODE (REPLACE_MODE)
    ) u_replacer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_q),
        .touch_i      (touch_i & hit),
        .touch_way_i  (hit_way),
        .commit_i     (commit),
        .commit_way_i (lat_way_q),
        .victim_way_o (rep_victim)
    );

    assign victim_way_o = (state_q == S_FILL) ? lat_way_q : rep_victim;
    assign sel_way      = hit ? hit_way : victim_way_o;
    assign hit_o        = hit;
    assign hit_way_o    = hit_way;
    assign dirty_o      = dirty_q[sel_way];
    assign tag_o        = tag_q[sel_way];
    assign read_data_o  = data_q[sel_way][cpu_word];
    assign busy_o       = (state_q != S_IDLE);

    assign cpu_wr  = (state_q == S_IDLE) && hit && cpu_we_i;
    assign fill_wr = (state_q == S_FILL) && fill_we_i;
    assign commit  = fill_wr && fill_last_i;

    // Clean or invalid ways retire immediately; dirty ones wait for ready.
    assign in_flush      = (state_q == S_FLUSH);
    assign cur_dirty     = valid_q[idx_q] & dirty_q[idx_q];
    assign retire        = in_flush && (!cur_dirty || flush_ready_i);
    assign flush_valid_o = in_flush && cur_dirty;
    assign flush_done_o  = retire && (idx_q == WW'(WAYS - 1));
    assign flush_way_o   = in_flush ? idx_q : '0;
    assign flush_tag_o   = tag_q[idx_q];
    assign flush_data_o  = data_q[idx_q][flush_word_i];

    always_comb begin
        state_d   = state_q;
        lat_way_d = lat_way_q;
        lat_tag_d = lat_tag_q;
        idx_d     = idx_q;
        inv_d     = inv_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        case (state_q)
            S_IDLE: begin
                if (fill_start_i) begin
                    state_d   = S_FILL;
                    lat_way_d = rep_victim;
                    lat_tag_d = addr_tag;
                end else if (flush_start_i) begin
                    state_d = S_FLUSH;
                    idx_d   = '0;
                    inv_d   = flush_inv_i;
                end
                if (cpu_wr) begin
                    dirty_d[hit_way] = 1'b1;
                end
            end
            S_FILL: begin
                if (commit) begin
                    valid_d[lat_way_q] = 1'b1;
                    dirty_d[lat_way_q] = 1'b0;
                    state_d            = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (retire) begin
                    dirty_d[idx_q] = 1'b0;
                    if (inv_q) begin
                        valid_d[idx_q] = 1'b0;
                    end
                    if (idx_q == WW'(WAYS - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + WW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            lat_way_q <= '0;
            lat_tag_q <= '0;
            idx_q     <= '0;
            inv_q     <= 1'b0;
            valid_q   <= '0;
            dirty_q   <= '0;
        end else begin
            state_q   <= state_d;
            lat_way_q <= lat_way_d;
            lat_tag_q <= lat_tag_d;
            idx_q     <= idx_d;
            inv_q     <= inv_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
        end
    end

    // Tag and data arrays carry no reset; valid qualifies their contents.
    always_ff @(posedge clk_i) begin
        if (cpu_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_i[b]) begin
                    data_q[hit_way][cpu_word][8*b +: 8] <= write_data_i[8*b +: 8];
                end
            end
        end
        if (fill_wr) begin
            data_q[lat_way_q][fill_word] <= fill_data_i;
        end
        if (commit) begin
            tag_q[lat_way_q] <= lat_tag_q;
        end
    end

endmodule

// File: tb/tb_assoc_set.sv
module tb_assoc_set;
  localparam int WAYS = 4;
  localparam int OFFW = 4;
  localparam int TAGW = 26;
  localparam int NI = 3;  // instance k uses replacement mode k
  localparam int ST_IDLE = 0, ST_FILL = 1, ST_FLUSH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] addr_i = '0;
  logic cpu_we_i = 0;
  logic [3:0] byte_en_i = '0;
  logic [31:0] write_data_i = '0;
  logic touch_i = 0;
  logic fill_start_i = 0;
  logic fill_we_i = 0;
  logic [31:0] fill_addr_i = '0;
  logic [31:0] fill_data_i = '0;
  logic fill_last_i = 0;
  logic flush_start_i = 0;
  logic flush_inv_i = 0;
  logic flush_ready_i = 0;
  logic [1:0] flush_word_i = '0;

  logic hit [NI];
  logic [1:0] hit_way [NI];
  logic [1:0] victim [NI];
  logic dirty [NI];
  logic [25:0] tag [NI];
  logic [31:0] rdata [NI];
  logic busy [NI];
  logic fvalid [NI];
  logic [1:0] fway [NI];
  logic [25:0] ftag [NI];
  logic [31:0] fdata [NI];
  logic fdone [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assoc_set #(
      .TAG_WIDTH(TAGW), .OFFSET_WIDTH(OFFW), .WAYS(WAYS), .REPLACE_MODE(g)
    ) u_dut (
      .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .cpu_we_i(cpu_we_i),
      .byte_en_i(byte_en_i), .write_data_i(write_data_i), .touch_i(touch_i),
      .fill_start_i(fill_start_i), .fill_we_i(fill_we_i), .fill_addr_i(fill_addr_i),
      .fill_data_i(fill_data_i), .fill_last_i(fill_last_i),
      .flush_start_i(flush_start_i), .flush_inv_i(flush_inv_i),
      .flush_ready_i(flush_ready_i), .flush_word_i(flush_word_i),
      .hit_o(hit[g]), .hit_way_o(hit_way[g]), .victim_way_o(victim[g]),
      .dirty_o(dirty[g]), .tag_o(tag[g]), .read_data_o(rdata[g]), .busy_o(busy[g]),
      .flush_valid_o(fvalid[g]), .flush_way_o(fway[g]), .flush_tag_o(ftag[g]),
      .flush_data_o(fdata[g]), .flush_done_o(fdone[g])
    );
  end

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h exp=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_valid [NI][WAYS];
  bit m_dirty [NI][WAYS];
  bit [25:0] m_tag [NI][WAYS];
  bit m_tag_k [NI][WAYS];
  bit [31:0] m_data [NI][WAYS][4];
  bit m_data_k [NI][WAYS][4];
  int m_state [NI];
  int m_lat [NI];
  bit [25:0] m_lat_tag [NI];
  int m_idx [NI];
  bit m_inv [NI];
  int lru_q[$];        // most recently used at the front (instance 0)
  int fifo_ptr;        // instance 1
  bit [7:0] lfsr;      // instance 2

  bit e_hit; int e_hw; int e_vic; int e_sel; bit e_dirty;
  bit [25:0] e_tag; bit e_tag_k; bit [31:0] e_rd; bit e_rd_k;
  bit e_busy; bit e_fv; int e_fw; bit e_fdone;
  bit [25:0] e_ftag; bit [31:0] e_fdata; bit e_fdata_k;

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[k][w] = 0;
        m_dirty[k][w] = 0;
      end
      m_state[k] = ST_IDLE;
      m_idx[k] = 0;
    end
    lru_q = '{0, 1, 2, 3};
    fifo_ptr = 0;
    lfsr = 8'h01;
  endtask

  task automatic model_eval(input int k);
    bit [25:0] tg;
    int wd;
    bit found;
    bit cur;
    tg = addr_i[31:6];
    wd = int'(addr_i[3:2]);
    e_hit = 0;
    e_hw = 0;
    for (int w = 0; w < WAYS; w++)
      if (!e_hit && m_valid[k][w] && m_tag[k][w] == tg &&
          !(m_state[k] == ST_FILL && m_lat[k] == w)) begin
        e_hit = 1;
        e_hw = w;
      end
    if (m_state[k] == ST_FILL) e_vic = m_lat[k];
    else begin
      found = 0;
      e_vic = 0;
      for (int w = 0; w < WAYS; w++)
        if (!found && !m_valid[k][w]) begin
          found = 1;
          e_vic = w;
        end
      if (!found) begin
        if (k == 0) e_vic = lru_q[lru_q.size()-1];
        else if (k == 1) e_vic = fifo_ptr;
        else e_vic = int'(lfsr) % WAYS;
      end
    end
    e_sel = e_hit ? e_hw : e_vic;
    e_dirty = m_dirty[k][e_sel];
    e_tag = m_tag[k][e_sel];
    e_tag_k = m_tag_k[k][e_sel];
    e_rd = m_data[k][e_sel][wd];
    e_rd_k = m_data_k[k][e_sel][wd];
    e_busy = (m_state[k] != ST_IDLE);
    cur = m_valid[k][m_idx[k]] && m_dirty[k][m_idx[k]];
    e_fv = (m_state[k] == ST_FLUSH) && cur;
    e_fw = (m_state[k] == ST_FLUSH) ? m_idx[k] : 0;
    e_fdone = (m_state[k] == ST_FLUSH) && m_idx[k] == WAYS - 1 && (!cur || flush_ready_i);
    e_ftag = m_tag[k][m_idx[k]];
    e_fdata = m_data[k][m_idx[k]][flush_word_i];
    e_fdata_k = m_data_k[k][m_idx[k]][flush_word_i];
  endtask

  task automatic lru_touch(input int w);
    for (int i = 0; i < lru_q.size(); i++)
      if (lru_q[i] == w) begin
        lru_q.delete(i);
        break;
      end
    lru_q.push_front(w);
  endtask

  task automatic model_step(input int k);
    bit commit;
    bit cur;
    int wd;
    int fw;
    commit = 0;
    wd = int'(addr_i[3:2]);
    fw = int'(fill_addr_i[3:2]);
    model_eval(k);
    case (m_state[k])
      ST_IDLE: begin
        if (fill_start_i) begin
          m_state[k] = ST_FILL;
          m_lat[k] = e_vic;
          m_lat_tag[k] = addr_i[31:6];
        end else if (flush_start_i) begin
          m_state[k] = ST_FLUSH;
          m_idx[k] = 0;
          m_inv[k] = flush_inv_i;
        end
        if (cpu_we_i && e_hit) begin
          for (int b = 0; b < 4; b++)
            if (byte_en_i[b]) m_data[k][e_hw][wd][8*b +: 8] = write_data_i[8*b +: 8];
          m_dirty[k][e_hw] = 1;
        end
      end
      ST_FILL: begin
        if (fill_we_i) begin
          m_data[k][m_lat[k]][fw] = fill_data_i;
          m_data_k[k][m_lat[k]][fw] = 1;
          if (fill_last_i) begin
            m_tag[k][m_lat[k]] = m_lat_tag[k];
            m_tag_k[k][m_lat[k]] = 1;
            m_valid[k][m_lat[k]] = 1;
            m_dirty[k][m_lat[k]] = 0;
            m_state[k] = ST_IDLE;
            commit = 1;
          end
        end
      end
      default: begin
        cur = m_valid[k][m_idx[k]] && m_dirty[k][m_idx[k]];
        if (!cur || flush_ready_i) begin
          m_dirty[k][m_idx[k]] = 0;
          if (m_inv[k]) m_valid[k][m_idx[k]] = 0;
          if (m_idx[k] == WAYS - 1) m_state[k] = ST_IDLE;
          else m_idx[k]++;
        end
      end
    endcase
    if (commit) begin
      if (k == 0) lru_touch(m_lat[k]);
      if (k == 1) fifo_ptr = (fifo_ptr + 1) % WAYS;
    end else if (touch_i && e_hit && k == 0) begin
      lru_touch(e_hw);
    end
  endtask

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) model_reset();
    else begin
      for (int k = 0; k < NI; k++) model_step(k);
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        model_eval(k);
        check("hit", k, 32'(hit[k]), 32'(e_hit));
        check("hit_way", k, 32'(hit_way[k]), 32'(e_hw));
        check("victim", k, 32'(victim[k]), 32'(e_vic));
        check("dirty", k, 32'(dirty[k]), 32'(e_dirty));
        check("busy", k, 32'(busy[k]), 32'(e_busy));
        check("flush_valid", k, 32'(fvalid[k]), 32'(e_fv));
        check("flush_way", k, 32'(fway[k]), 32'(e_fw));
        check("flush_done", k, 32'(fdone[k]), 32'(e_fdone));
        if (e_tag_k) check("tag", k, 32'(tag[k]), 32'(e_tag));
        if (e_hit && e_rd_k) check("read_data", k, rdata[k], e_rd);
        if (e_fv) check("flush_tag", k, 32'(ftag[k]), 32'(e_ftag));
        if (e_fv && e_fdata_k) check("flush_data", k, fdata[k], e_fdata);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_we_i = 0; touch_i = 0; fill_start_i = 0; fill_we_i = 0;
    fill_last_i = 0; flush_start_i = 0; flush_ready_i = 0;
  endtask

  task automatic apply_reset();
    rst_i = 1;
    tick();
    rst_i = 0;
  endtask

  function automatic logic [31:0] mk_addr(input logic [25:0] t, input int w);
    logic [1:0] w2;
    w2 = w[1:0];
    return {t, 2'b00, w2, 2'b00};
  endfunction

  task automatic do_fill(input logic [25:0] t, input logic [31:0] d0, input int nw);
    addr_i = mk_addr(t, 0);
    fill_start_i = 1;
    tick();
    fill_start_i = 0;
    for (int w = 0; w < nw; w++) begin
      fill_we_i = 1;
      fill_addr_i = mk_addr(26'h0, w);
      fill_data_i = d0 + w;
      fill_last_i = (w == 3);
      tick();
    end
    fill_we_i = 0;
    fill_last_i = 0;
  endtask

  task automatic do_touch(input logic [25:0] t);
    addr_i = mk_addr(t, 0);
    touch_i = 1;
    tick();
    touch_i = 0;
  endtask

  task automatic cpu_write(input logic [25:0] t, input int w, input logic [3:0] be,
                           input logic [31:0] d);
    addr_i = mk_addr(t, w);
    cpu_we_i = 1;
    byte_en_i = be;
    write_data_i = d;
    tick();
    cpu_we_i = 0;
  endtask

  // ---------------- stimulus ----------------
  int seen_q[$];
  bit got_done;
  int wait_cnt;
  logic [31:0] r32;
  logic [5:0] r6;
  logic [25:0] rtag;

  initial begin
    idle_inputs();
    rst_i = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 0;
    chk_en = 1;

    // Reset state
    addr_i = 32'h0000_1230;
    #1;
    check("rst_hit", 0, 32'(hit[0]), 32'd0);
    check("rst_victim", 0, 32'(victim[0]), 32'd0);
    check("rst_dirty", 0, 32'(dirty[0]), 32'd0);
    check("rst_busy", 0, 32'(busy[0]), 32'd0);

    // Line fill of tag 0x48
    do_fill(26'h48, 32'hA0, 4);
    for (int w = 0; w < 4; w++) begin
      addr_i = mk_addr(26'h48, w);
      #1;
      check("fill_hit", w, 32'(hit[0]), 32'd1);
      check("fill_rd", w, rdata[0], 32'hA0 + w);
    end
    check("fill_hitway", 0, 32'(hit_way[0]), 32'd0);
    check("fill_dirty", 0, 32'(dirty[0]), 32'd0);

    // Byte-enable write
    cpu_write(26'h48, 1, 4'b0101, 32'hFFFF_FFFF);
    #1;
    check("bytewr_rd", 0, rdata[0], 32'h00FF_00FF);
    check("bytewr_dirty", 0, 32'(dirty[0]), 32'd1);

    // LRU / FIFO ordering
    apply_reset();
    for (int i = 0; i < 4; i++) do_fill(26'h10 + i, 32'h100 * i, 4);
    do_touch(26'h10);
    do_touch(26'h12);
    do_touch(26'h11);
    #1;
    check("lru_victim", 0, 32'(victim[0]), 32'd3);
    check("fifo_victim", 1, 32'(victim[1]), 32'd0);
    do_touch(26'h13);
    #1;
    check("lru_victim2", 0, 32'(victim[0]), 32'd0);

    // Flush with ways 1 and 3 dirty, ready delayed 2 cycles
    cpu_write(26'h11, 0, 4'hF, 32'h1111_0000);
    cpu_write(26'h13, 2, 4'hF, 32'h3333_0002);
    flush_inv_i = 0;
    flush_start_i = 1;
    tick();
    flush_start_i = 0;
    got_done = 0;
    wait_cnt = 0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      #1;
      if (fdone[0]) got_done = 1;
      if (fvalid[0]) begin
        if (wait_cnt == 2) begin
          flush_ready_i = 1;
          seen_q.push_back(int'(fway[0]));
          wait_cnt = 0;
          #1;
          if (fdone[0]) got_done = 1;
        end else wait_cnt++;
      end
      tick();
      flush_ready_i = 0;
    end
    check("flush_done_seen", 0, 32'(got_done), 32'd1);
    check("flush_count", 0, 32'(seen_q.size()), 32'd2);
    if (seen_q.size() == 2) begin
      check("flush_way_a", 0, 32'(seen_q[0]), 32'd1);
      check("flush_way_b", 0, 32'(seen_q[1]), 32'd3);
    end
    for (int i = 0; i < 4; i++) begin
      addr_i = mk_addr(26'h10 + i, 0);
      #1;
      check("post_flush_dirty", i, 32'(dirty[0]), 32'd0);
    end

    // Reset in the middle of a fill
    apply_reset();
    do_fill(26'h30, 32'h300, 4);
    do_fill(26'h31, 32'h310, 2);
    rst_i = 1;
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rstfill_busy", k, 32'(busy[k]), 32'd0);
      check("rstfill_fvalid", k, 32'(fvalid[k]), 32'd0);
    end
    tick();
    rst_i = 0;
    addr_i = mk_addr(26'h31, 0);
    #1;
    check("rstfill_hit", 0, 32'(hit[0]), 32'd0);
    check("rstfill_victim", 0, 32'(victim[0]), 32'd0);
    do_fill(26'h31, 32'h710, 4);
    addr_i = mk_addr(26'h31, 2);
    #1;
    check("refill_hitway", 0, 32'(hit_way[0]), 32'd0);
    check("refill_rd", 0, rdata[0], 32'h712);

    // Randomised traffic, checked every cycle by the compare process
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      rtag = 26'h40 + 26'($urandom_range(0, 5));
      r6 = 6'($urandom());
      addr_i = {rtag, r6};
      cpu_we_i = ($urandom_range(0, 2) == 0);
      byte_en_i = 4'($urandom_range(0, 15));
      write_data_i = $urandom();
      touch_i = $urandom_range(0, 1) != 0;
      fill_start_i = ($urandom_range(0, 7) == 0);
      fill_we_i = $urandom_range(0, 1) != 0;
      fill_last_i = ($urandom_range(0, 3) == 0);
      r32 = $urandom();
      fill_addr_i = r32;
      fill_data_i = $urandom();
      flush_start_i = ($urandom_range(0, 15) == 0);
      flush_inv_i = $urandom_range(0, 1) != 0;
      flush_ready_i = $urandom_range(0, 1) != 0;
      flush_word_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        rst_i = 1;
        tick();
        rst_i = 0;
      end else begin
        tick();
      end
    end
    idle_inputs();
    repeat (2) tick();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
